agc_block_accumulator: RTL and testbench
========================================

AGC_BLOCK_ACCUMULATOR -- requirements
Module: agc_block_accumulator

Interface
REQ-001 SHALL provide parameter IN_W, default 12, input sample width in bits.
REQ-002 SHALL provide parameter LOG2_N, default 3, log2 of samples per block (N = 2^LOG2_N, LOG2_N >= 1).
REQ-003 SHALL provide parameter SIGNED, default 0, 1 = two's-complement samples, 0 = unsigned.
REQ-004 SHALL derive OUT_W = IN_W + LOG2_N internally; it is not user-settable.
REQ-005 SHALL have one clock and a synchronous, active-high reset: i_clk input 1, rising-edge clock; i_rst input 1, synchronous active-high reset.
REQ-006 i_clear  input  1  discard partial block, restart count.
REQ-007 i_valid  input  1  i_num holds a sample this cycle.
REQ-008 i_num  input  IN_W  input sample.
REQ-009 i_ready  input  1  downstream accepts o_num this cycle.
REQ-010 o_num  output  OUT_W  block result, stable while o_valid high.
REQ-011 o_valid  output  1  o_num holds an unconsumed result.
REQ-012 o_drop  output  1  one-cycle pulse: unconsumed result overwritten.
REQ-013 o_count  output  LOG2_N  samples accepted in current partial block.

Function
REQ-014 SHALL accept a sample on every cycle with i_valid=1 and i_clear=0; no input backpressure.
REQ-015 SHALL extend i_num to OUT_W: sign extension if SIGNED=1, zero extension if SIGNED=0; the sum cannot overflow OUT_W.
REQ-016 SHALL load the running sum with the extended sample when o_count=0, and add it to the running sum otherwise.
REQ-017 SHALL increment o_count per accepted sample, wrapping N-1 -> 0 on the Nth sample.
REQ-018 On the Nth accepted sample, SHALL register the full N-sample result into o_num and set o_valid=1 on the following cycle (latency 1 cycle).
REQ-019 Cycles with i_valid=0 SHALL leave the sum and o_count unchanged; gaps do not affect the result.
REQ-020 Output FSM SHALL have two states: OUT_EMPTY (o_valid=0) and OUT_FULL (o_valid=1).
REQ-021 OUT_EMPTY -> OUT_FULL on block completion.
REQ-022 OUT_FULL -> OUT_EMPTY when i_ready=1 and no block completes in the same cycle.
REQ-023 OUT_FULL with i_ready=1 and a simultaneous completion SHALL stay in OUT_FULL with the new o_num and no o_drop.
REQ-024 OUT_FULL with i_ready=0 and a completion SHALL overwrite o_num, stay in OUT_FULL, and pulse o_drop high for one cycle.
REQ-025 o_num SHALL hold its value in all other cycles.
REQ-026 i_clear=1 SHALL set o_count=0 and discard the partial sum next cycle; the output register, o_valid and FSM state are unaffected.
REQ-027 i_clear and i_valid in the same cycle: clear wins, the sample is discarded, no completion.

Reset
REQ-028 i_rst=1 at a rising i_clk edge SHALL set o_num=0, o_valid=0, o_drop=0, o_count=0, running sum=0, FSM=OUT_EMPTY.
REQ-029 i_rst SHALL take priority over i_clear, i_valid and i_ready; a partial block or pending result is lost.

Configuration
REQ-030 Macro ACC_MEAN_EN defined: o_num SHALL be the block sum shifted right by LOG2_N (arithmetic shift if SIGNED=1, logical if SIGNED=0), then extended to OUT_W.
REQ-031 Macro ACC_MEAN_EN undefined: o_num SHALL be the full N-sample sum.
REQ-032 All handshake timing, o_drop and o_count behaviour SHALL be identical with and without the macro.

Verification (IN_W=12, LOG2_N=3, ACC_MEAN_EN undefined unless stated)
REQ-033 SIGNED=0, 8 consecutive samples 12'hFFF, i_ready=1 -> o_valid high one cycle after 8th sample, o_num=15'h7FF8, then low.
REQ-034 SIGNED=1, 8 samples 12'h800 with idle cycles between them -> o_num=15'h4000 (-16384), o_count steps 1..7 then 0.
REQ-035 i_ready=0; block of 8x1 then block of 8x2 -> o_num=8 first, then o_drop pulses once, o_num=16; i_ready=1 -> o_valid falls next cycle.
REQ-036 3 samples of 5, i_clear with i_valid=1, then 8 samples of 1 -> o_count=0 after clear, o_num=8.
REQ-037 5 samples of 7, i_rst for one cycle, 8 samples of 2 -> all outputs 0 after reset, then o_num=16.
REQ-038 ACC_MEAN_EN defined, SIGNED=1, 8 samples of -100 -> o_num=-100 sign-extended (15'h7F9C).

Source files
------------

// File: rtl/agc_block_accumulator.sv
// -----------------------------------------------------------------------------
// agc_block_accumulator
//
// Accumulates blocks of N = 2^LOG2_N input samples for an AGC power/level
// estimator and presents each block result through a one-deep output register
// with a valid/ready handshake. The input side never stalls. If a new block
// completes while an earlier result is still unconsumed, the old result is
// overwritten and o_drop pulses for one cycle.
//
// Optional feature (compile-time macro):
//   ACC_MEAN_EN - when defined, o_num carries the block mean (the sum shifted
//                 right by LOG2_N, arithmetic for signed samples). When it is
//                 undefined, o_num carries the full block sum. The handshake,
//                 o_drop and o_count timing are the same in both builds.
//
// Parameters:
//   IN_W    - input sample width
//   LOG2_N  - log2 of samples per block (>= 1)
//   SIGNED  - 1: two's-complement samples, 0: unsigned samples
//   OUT_W   - derived, IN_W + LOG2_N (wide enough that a block sum never overflows)
//
// Ports:
//   i_clk    - rising-edge clock
//   i_rst    - synchronous active-high reset (highest priority)
//   i_clear  - drop the partial block and restart the sample count
//   i_valid  - i_num carries a sample this cycle
//   i_num    - input sample [IN_W]
//   i_ready  - downstream consumes o_num this cycle
//   o_num    - block result [OUT_W], stable while o_valid is high
//   o_valid  - o_num holds an unconsumed result
//   o_drop   - one-cycle pulse: an unconsumed result was overwritten
//   o_count  - samples accepted so far in the current partial block [LOG2_N]
// -----------------------------------------------------------------------------
module agc_block_accumulator #(
  parameter int IN_W   = 12,
  parameter int LOG2_N = 3,
  parameter int SIGNED = 0,
  localparam int OUT_W = IN_W + LOG2_N
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_valid,
  input  logic [IN_W-1:0]   i_num,
  input  logic              i_ready,
  output logic [OUT_W-1:0]  o_num,
  output logic              o_valid,
  output logic              o_drop,
  output logic [LOG2_N-1:0] o_count
);

  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  localparam logic [LOG2_N-1:0] COUNT_ONE  = LOG2_N'(1'b1);
  localparam logic [LOG2_N-1:0] COUNT_LAST = '1;

  // Widen a sample to the accumulator width; sign- or zero-fill the top bits.
  function automatic logic [OUT_W-1:0] extend_sample(input logic [IN_W-1:0] sample);
    if (SIGNED != 32'sd0) begin
      extend_sample = {{LOG2_N{sample[IN_W-1]}}, sample};
    end else begin
      extend_sample = {{LOG2_N{1'b0}}, sample};
    end
  endfunction

  logic [OUT_W-1:0]  sum_r;
  logic [LOG2_N-1:0] count_r;
  logic [OUT_W-1:0]  num_r;
  logic              drop_r;
  out_state_t        state_r;
  out_state_t        state_next_s;

  logic              accept_s;
  logic              complete_s;
  logic              drop_s;
  logic [OUT_W-1:0]  ext_s;
  logic [OUT_W-1:0]  block_sum_s;
  logic [OUT_W-1:0]  result_s;

  // A clear in the same cycle as a sample discards that sample.
  assign accept_s   = i_valid & ~i_clear;
  assign complete_s = accept_s & (count_r == COUNT_LAST);
  assign ext_s      = extend_sample(i_num);

  // The first sample of a block loads the sum instead of adding, so no
  // separate sum clear is needed between blocks.
  always_comb begin
    block_sum_s = sum_r;
    if (count_r == '0) begin
      block_sum_s = ext_s;
    end else begin
      block_sum_s = sum_r + ext_s;
    end
  end

`ifdef ACC_MEAN_EN
  // Block mean: divide by N with a shift; the shift fills with sign or zero.
  always_comb begin
    result_s = block_sum_s;
    if (SIGNED != 32'sd0) begin
      result_s = OUT_W'($signed(block_sum_s) >>> LOG2_N);
    end else begin
      result_s = block_sum_s >> LOG2_N;
    end
  end
`else
  // Block sum passed through unchanged.
  always_comb begin
    result_s = block_sum_s;
  end
`endif

  // Output FSM next state and overwrite detection.
  always_comb begin
    state_next_s = state_r;
    drop_s       = 1'b0;
    case (state_r)
      OUT_EMPTY: begin
        if (complete_s) begin
          state_next_s = OUT_FULL;
        end else begin
          state_next_s = OUT_EMPTY;
        end
      end
      OUT_FULL: begin
        if (complete_s) begin
          // A result consumed this same cycle is not lost.
          state_next_s = OUT_FULL;
          drop_s       = ~i_ready;
        end else if (i_ready) begin
          state_next_s = OUT_EMPTY;
        end else begin
          state_next_s = OUT_FULL;
        end
      end
      default: begin
        state_next_s = OUT_EMPTY;
      end
    endcase
  end

  // Running sum and sample counter; the counter wraps to 0 on the Nth sample.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sum_r   <= '0;
      count_r <= '0;
    end else if (i_clear) begin
      sum_r   <= '0;
      count_r <= '0;
    end else if (i_valid) begin
      sum_r   <= block_sum_s;
      count_r <= count_r + COUNT_ONE;
    end else begin
      sum_r   <= sum_r;
      count_r <= count_r;
    end
  end

  // Output register, drop pulse and FSM state; i_clear does not touch these.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      num_r   <= '0;
      drop_r  <= 1'b0;
      state_r <= OUT_EMPTY;
    end else begin
      if (complete_s) begin
        num_r <= result_s;
      end else begin
        num_r <= num_r;
      end
      drop_r  <= drop_s;
      state_r <= state_next_s;
    end
  end

  assign o_num   = num_r;
  assign o_valid = (state_r == OUT_FULL);
  assign o_drop  = drop_r;
  assign o_count = count_r;

endmodule

// File: tb/tb_agc_block_accumulator.sv
// -----------------------------------------------------------------------------
// tb_agc_block_accumulator
//
// Directed bench for agc_block_accumulator. Two instances (unsigned and signed
// samples, IN_W=12, LOG2_N=3) share one stimulus stream. Expected o_num values
// are hand-computed block sums together with the matching block means; the
// pick_num function selects the mean when ACC_MEAN_EN is defined.
// -----------------------------------------------------------------------------
module tb_agc_block_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        valid = 1'b0;
  logic [11:0] num = 12'h000;
  logic        ready = 1'b0;

  logic [14:0] u_num;
  logic        u_valid;
  logic        u_drop;
  logic [2:0]  u_count;
  logic [14:0] s_num;
  logic        s_valid;
  logic        s_drop;
  logic [2:0]  s_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  agc_block_accumulator #(.IN_W(12), .LOG2_N(3), .SIGNED(0)) dut_u (
    .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_valid(valid), .i_num(num),
    .i_ready(ready), .o_num(u_num), .o_valid(u_valid), .o_drop(u_drop), .o_count(u_count)
  );

  agc_block_accumulator #(.IN_W(12), .LOG2_N(3), .SIGNED(1)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_valid(valid), .i_num(num),
    .i_ready(ready), .o_num(s_num), .o_valid(s_valid), .o_drop(s_drop), .o_count(s_count)
  );

  function automatic logic [14:0] pick_num(input logic [14:0] sum_val, input logic [14:0] mean_val);
`ifdef ACC_MEAN_EN
    pick_num = mean_val;
`else
    pick_num = sum_val;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] v);
    valid = 1'b1;
    num   = v;
    tick();
    valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++;
    if ({u_num, u_valid, u_drop, u_count} !== 20'd0) $display("FAIL reset_u got num=%h v=%b d=%b c=%0d want all 0", u_num, u_valid, u_drop, u_count);
    else pass_cnt++;
    total_cnt++;
    if ({s_num, s_valid, s_drop, s_count} !== 20'd0) $display("FAIL reset_s got num=%h v=%b d=%b c=%0d want all 0", s_num, s_valid, s_drop, s_count);
    else pass_cnt++;
  endtask

  task automatic test_full_scale();
    logic [14:0] exp_u;
    logic [14:0] exp_s;
    exp_u = pick_num(15'h7FF8, 15'h0FFF);
    exp_s = pick_num(15'h7FF8, 15'h7FFF);
    ready = 1'b1;
    for (int i = 0; i < 7; i++) send(12'hFFF);
    total_cnt++;
    if (u_valid !== 1'b0 || u_count !== 3'd7) $display("FAIL full_pre got v=%b c=%0d want v=0 c=7", u_valid, u_count);
    else pass_cnt++;
    send(12'hFFF);
    total_cnt++;
    if (u_valid !== 1'b1 || u_num !== exp_u) $display("FAIL full_u got v=%b num=%h want v=1 num=%h", u_valid, u_num, exp_u);
    else pass_cnt++;
    total_cnt++;
    if (s_valid !== 1'b1 || s_num !== exp_s) $display("FAIL full_s got v=%b num=%h want v=1 num=%h", s_valid, s_num, exp_s);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (u_valid !== 1'b0 || u_count !== 3'd0) $display("FAIL full_post got v=%b c=%0d want v=0 c=0", u_valid, u_count);
    else pass_cnt++;
  endtask

  task automatic test_gaps();
    logic [14:0] exp_s;
    logic [14:0] exp_u;
    int bad;
    exp_s = pick_num(15'h4000, 15'h7800);
    exp_u = pick_num(15'h4000, 15'h0800);
    bad = 0;
    ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      send(12'h800);
      if (s_count !== 3'(k % 8)) bad++;
      tick();
      if (s_count !== 3'(k % 8)) bad++;
      if (k == 8) begin
        total_cnt++;
        if (s_num !== exp_s) $display("FAIL gaps_s got num=%h want %h", s_num, exp_s);
        else pass_cnt++;
        total_cnt++;
        if (u_num !== exp_u) $display("FAIL gaps_u got num=%h want %h", u_num, exp_u);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL gaps_count got %0d bad count samples want 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_drop();
    ready = 1'b0;
    for (int i = 0; i < 8; i++) send(12'h001);
    total_cnt++;
    if (u_valid !== 1'b1 || u_num !== pick_num(15'd8, 15'd1) || u_drop !== 1'b0)
      $display("FAIL drop_first got v=%b num=%h d=%b want v=1 num=%h d=0", u_valid, u_num, u_drop, pick_num(15'd8, 15'd1));
    else pass_cnt++;
    for (int i = 0; i < 7; i++) send(12'h002);
    total_cnt++;
    if (u_drop !== 1'b0 || u_num !== pick_num(15'd8, 15'd1)) $display("FAIL drop_hold got d=%b num=%h want d=0 num=%h", u_drop, u_num, pick_num(15'd8, 15'd1));
    else pass_cnt++;
    send(12'h002);
    total_cnt++;
    if (u_drop !== 1'b1 || u_valid !== 1'b1 || u_num !== pick_num(15'd16, 15'd2))
      $display("FAIL drop_pulse got d=%b v=%b num=%h want d=1 v=1 num=%h", u_drop, u_valid, u_num, pick_num(15'd16, 15'd2));
    else pass_cnt++;
    tick();
    total_cnt++;
    if (u_drop !== 1'b0 || u_valid !== 1'b1) $display("FAIL drop_once got d=%b v=%b want d=0 v=1", u_drop, u_valid);
    else pass_cnt++;
    ready = 1'b1;
    tick();
    total_cnt++;
    if (u_valid !== 1'b0 || u_num !== pick_num(15'd16, 15'd2)) $display("FAIL drop_consume got v=%b num=%h want v=0 num=%h", u_valid, u_num, pick_num(15'd16, 15'd2));
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    ready = 1'b0;
    for (int i = 0; i < 8; i++) send(12'h003);
    for (int i = 0; i < 7; i++) send(12'h004);
    ready = 1'b1;
    send(12'h004);
    total_cnt++;
    if (u_valid !== 1'b1 || u_drop !== 1'b0 || u_num !== pick_num(15'd32, 15'd4))
      $display("FAIL b2b_swap got v=%b d=%b num=%h want v=1 d=0 num=%h", u_valid, u_drop, u_num, pick_num(15'd32, 15'd4));
    else pass_cnt++;
    tick();
    total_cnt++;
    if (u_valid !== 1'b0 || u_drop !== 1'b0) $display("FAIL b2b_consume got v=%b d=%b want v=0 d=0", u_valid, u_drop);
    else pass_cnt++;
  endtask

  task automatic test_clear();
    ready = 1'b1;
    for (int i = 0; i < 3; i++) send(12'h005);
    clear = 1'b1;
    send(12'h005);
    clear = 1'b0;
    total_cnt++;
    if (u_count !== 3'd0 || u_valid !== 1'b0) $display("FAIL clear_count got c=%0d v=%b want c=0 v=0", u_count, u_valid);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) send(12'h001);
    total_cnt++;
    if (u_valid !== 1'b1 || u_num !== pick_num(15'd8, 15'd1)) $display("FAIL clear_block got v=%b num=%h want v=1 num=%h", u_valid, u_num, pick_num(15'd8, 15'd1));
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    ready = 1'b0;
    for (int i = 0; i < 5; i++) send(12'h007);
    rst = 1'b1;
    valid = 1'b1;
    num = 12'h007;
    tick();
    rst = 1'b0;
    valid = 1'b0;
    total_cnt++;
    if ({u_num, u_valid, u_drop, u_count} !== 20'd0) $display("FAIL rstmid_zero got num=%h v=%b d=%b c=%0d want all 0", u_num, u_valid, u_drop, u_count);
    else pass_cnt++;
    ready = 1'b1;
    for (int i = 0; i < 8; i++) send(12'h002);
    total_cnt++;
    if (u_valid !== 1'b1 || u_num !== pick_num(15'd16, 15'd2)) $display("FAIL rstmid_block got v=%b num=%h want v=1 num=%h", u_valid, u_num, pick_num(15'd16, 15'd2));
    else pass_cnt++;
    tick();
  endtask

  task automatic test_negative();
    logic [14:0] exp_s;
    logic [14:0] exp_u;
    exp_s = pick_num(15'h7CE0, 15'h7F9C);
    exp_u = pick_num(15'h7CE0, 15'h0F9C);
    ready = 1'b1;
    for (int i = 0; i < 8; i++) send(12'hF9C);
    total_cnt++;
    if (s_valid !== 1'b1 || s_num !== exp_s) $display("FAIL neg_s got v=%b num=%h want v=1 num=%h", s_valid, s_num, exp_s);
    else pass_cnt++;
    total_cnt++;
    if (u_num !== exp_u) $display("FAIL neg_u got num=%h want %h", u_num, exp_u);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_gaps();
    test_drop();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    test_negative();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
